// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_N    = 10;
   localparam int ITER_CNT = DIV_N;
   localparam int CNT_W    = 4;

   localparam logic [DIV_N-1:0] DIV0_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: state machine plus iteration counter.
//
// state | meaning
// IDLE  | waiting for start; previous Q/ov still presented
// LOAD  | capture operands, clear datapath, detect divide-by-zero
// ITER  | one quotient bit per cycle, N cycles
// DONE  | result valid; held until start drops
module div_ctrl
   import div_pkg::*;
#(
   parameter int N = ITER_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic b_zero,
   output logic load,
   output logic iter,
   output logic busy,
   output logic valid
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Iteration counter: cleared on load, stepped once per iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (iter) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      iter      = 1'b0;
      busy      = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            load      = 1'b1;
            busy      = 1'b1;
            state_nxt = b_zero ? DONE : ITER;
         end
         ITER: begin
            iter = 1'b1;
            busy = 1'b1;
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            valid = 1'b1;
            if (!start) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/div_top.sv
// 10-bit unsigned restoring divider, one quotient bit per clock.
module div_top
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic         busy,
   output logic         valid,
   output logic         ov
);

   logic         load;
   logic         iter;
   logic [N-1:0] dvd;
   logic [N-1:0] dvs;
   // The partial remainder is always below the divisor, so its top bit of the
   // (N+1)-bit working value is always zero and is not stored.
   logic [N-1:0] rem;
   logic [N:0]   rem_sh;
   logic [N:0]   trial;

   div_ctrl #(.N(N)) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .b_zero (B == '0),
      .load   (load),
      .iter   (iter),
      .busy   (busy),
      .valid  (valid)
   );

   // Shifted remainder and trial subtraction for the current iteration.
   always_comb begin
      rem_sh = {rem, dvd[N-1]};
      trial  = rem_sh - {1'b0, dvs};
   end

   // Operand capture, remainder/quotient update, divide-by-zero flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd <= '0;
         dvs <= '0;
         rem <= '0;
         Q   <= '0;
         ov  <= 1'b0;
      end else if (load) begin
         dvd <= A;
         dvs <= B;
         rem <= '0;
         if (B == '0) begin
            Q  <= DIV0_Q;
            ov <= 1'b1;
         end else begin
            Q  <= '0;
            ov <= 1'b0;
         end
      end else if (iter) begin
         dvd <= {dvd[N-2:0], 1'b0};
         if (!trial[N]) begin
            rem <= trial[N-1:0];
            Q   <= {Q[N-2:0], 1'b1};
         end else begin
            rem <= rem_sh[N-1:0];
            Q   <= {Q[N-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_div_top.sv
// Randomized self-checking bench for div_top against an arithmetic model.
module tb_div_top;

   logic       clk;
   logic       rst;
   logic       start;
   logic [9:0] A;
   logic [9:0] B;
   logic [9:0] Q;
   logic       busy;
   logic       valid;
   logic       ov;

   int vectors;
   int miscompares;

   div_top dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .busy  (busy),
      .valid (valid),
      .ov    (ov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, all-ones quotient on divide-by-zero.
   function automatic void ref_div(input logic [9:0] a, input logic [9:0] b,
                                   output logic [9:0] q, output logic o, output int lat);
      if (b == 10'd0) begin
         q   = 10'h3FF;
         o   = 1'b1;
         lat = 2;
      end else begin
         q   = a / b;
         o   = 1'b0;
         lat = 12;
      end
   endfunction

   // Raise start with operands, wait (bounded) for valid; start is left high.
   task automatic run_op(input logic [9:0] a, input logic [9:0] b,
                         output int cyc, output logic [9:0] q_o, output logic ov_o,
                         output logic first_busy, output logic overlap);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      cyc = 0;
      overlap = 1'b0;
      first_busy = 1'b0;
      while (cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) first_busy = busy;
         if (busy && valid) overlap = 1'b1;
         if (valid) break;
      end
      q_o  = Q;
      ov_o = ov;
   endtask

   task automatic drop_start();
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (Q !== 10'd0 || busy !== 1'b0 || valid !== 1'b0 || ov !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: Q=%0d busy=%b valid=%b ov=%b, required 0/0/0/0", Q, busy, valid, ov);
      end
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      logic [9:0] q;
      logic o, fb, ovl;
      run_op(10'd110, 10'd3, cyc, q, o, fb, ovl);
      vectors++;
      if (cyc !== 12 || q !== 10'd36 || o !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_110_3: cycles=%0d Q=%0d ov=%b, required 12/36/0", cyc, q, o);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (valid !== 1'b1 || busy !== 1'b0 || Q !== 10'd36) begin
         miscompares++;
         $display("FAIL basic_hold: valid=%b busy=%b Q=%0d, required 1/0/36", valid, busy, Q);
      end
      drop_start();
      vectors++;
      if (valid !== 1'b0 || busy !== 1'b0 || Q !== 10'd36 || ov !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: valid=%b busy=%b Q=%0d ov=%b, required 0/0/36/0", valid, busy, Q, ov);
      end
   endtask

   task automatic test_div_zero();
      int cyc;
      logic [9:0] q;
      logic o, fb, ovl;
      run_op(10'd100, 10'd0, cyc, q, o, fb, ovl);
      vectors++;
      if (cyc !== 2 || q !== 10'h3FF || o !== 1'b1) begin
         miscompares++;
         $display("FAIL div_zero: cycles=%0d Q=%h ov=%b, required 2/3ff/1", cyc, q, o);
      end
      drop_start();
   endtask

   task automatic test_directed();
      logic [9:0] ta [8] = '{10'd1023, 10'd5, 10'd1000, 10'd45, 10'd0, 10'd1023, 10'd1, 10'd512};
      logic [9:0] tb [8] = '{10'd1,    10'd7, 10'd10,   10'd9,  10'd5, 10'd1023, 10'd1023, 10'd2};
      for (int i = 0; i < 8; i++) begin
         int cyc, lat;
         logic [9:0] q, eq;
         logic o, eo, fb, ovl;
         ref_div(ta[i], tb[i], eq, eo, lat);
         run_op(ta[i], tb[i], cyc, q, o, fb, ovl);
         vectors++;
         if (cyc !== lat || q !== eq || o !== eo || fb !== 1'b1 || ovl !== 1'b0) begin
            miscompares++;
            $display("FAIL directed %0d/%0d: cycles=%0d Q=%0d ov=%b busy1=%b overlap=%b, required %0d/%0d/%b/1/0",
                     ta[i], tb[i], cyc, q, o, fb, ovl, lat, eq, eo);
         end
         drop_start();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int cyc, lat;
         logic [9:0] a, b, q, eq;
         logic o, eo, fb, ovl;
         a = 10'($urandom_range(0, 1023));
         if (i % 7 == 0)      b = 10'd0;
         else if (i % 3 == 0) b = 10'($urandom_range(1, 15));
         else                 b = 10'($urandom_range(1, 1023));
         ref_div(a, b, eq, eo, lat);
         run_op(a, b, cyc, q, o, fb, ovl);
         vectors++;
         if (cyc !== lat || q !== eq || o !== eo || ovl !== 1'b0) begin
            miscompares++;
            $display("FAIL random %0d/%0d: cycles=%0d Q=%0d ov=%b overlap=%b, required %0d/%0d/%b/0",
                     a, b, cyc, q, o, ovl, lat, eq, eo);
         end
         drop_start();
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [9:0] q;
      logic o, fb, ovl;
      @(negedge clk);
      A = 10'd500;
      B = 10'd7;
      start = 1'b1;
      @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (Q !== 10'((500 / 7) >> 5) || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL partial_q: Q=%0d busy=%b, required %0d/1", Q, busy, (500 / 7) >> 5);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (Q !== 10'd0 || busy !== 1'b0 || valid !== 1'b0 || ov !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: Q=%0d busy=%b valid=%b ov=%b, required 0/0/0/0", Q, busy, valid, ov);
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset_idle: busy=%b valid=%b, required 0/0", busy, valid);
      end
      run_op(10'd77, 10'd8, cyc, q, o, fb, ovl);
      vectors++;
      if (cyc !== 12 || q !== 10'd9 || o !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_op: cycles=%0d Q=%0d ov=%b, required 12/9/0", cyc, q, o);
      end
      drop_start();
   endtask

   task automatic test_operand_change();
      int cyc;
      logic got;
      @(negedge clk);
      A = 10'd200;
      B = 10'd6;
      start = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (cyc < 40 && !got) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (valid) begin
            got = 1'b1;
         end else if (cyc >= 2) begin
            A = 10'($urandom);
            B = 10'($urandom);
            start = 1'($urandom_range(0, 1));
         end
      end
      vectors++;
      if (cyc !== 12 || Q !== 10'd33 || ov !== 1'b0) begin
         miscompares++;
         $display("FAIL operand_change: cycles=%0d Q=%0d ov=%b, required 12/33/0", cyc, Q, ov);
      end
      drop_start();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      test_reset();
      test_basic();
      test_div_zero();
      test_directed();
      test_reset_mid();
      test_operand_change();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
